clk_div_meter: RTL and testbench

Measures a divided clock (or any slow periodic signal) against the system clock and reports its period, high time and power-of-two division ratio. It is the checking end of the clock-divider outputs: each divider tap can be routed to it for built-in self-test of the divide ratio and duty cycle. All logic runs in the single system clock domain. The measured input is treated as asynchronous and synchronised internally.

---
 rtl/clk_div_meter.sv | 169 ++++++++++++++++
 tb/tb_clk_div_meter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/clk_div_meter.sv
// rtl/clk_div_meter.sv - measures period, high time and power-of-two ratio of a slow input
// Input is synchronised, edge-detected one stage later, then timed by a small IDLE/ARM/MEAS FSM.
module clk_div_meter #(
   parameter int               CNT_W       = 28,
   parameter int               SYNC_STAGES = 2,
   parameter logic [CNT_W-1:0] TIMEOUT     = 28'd2048,
   parameter int               LOCK_COUNT  = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             sig_in,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_time,
   output logic [4:0]       ratio_log2,
   output logic             is_pow2,
   output logic             valid,
   output logic             locked,
   output logic             timeout
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ARM  = 2'd1;
   localparam logic [1:0] ST_MEAS = 2'd2;
   localparam logic [3:0] LOCK_C  = 4'(LOCK_COUNT);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s_q;
   logic                   rise_q;

   logic [1:0]       state_q,  state_d;
   logic [CNT_W-1:0] cnt_q,    cnt_d;
   logic [CNT_W-1:0] hi_q,     hi_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic [CNT_W-1:0] high_q,   high_d;
   logic [4:0]       ratio_q,  ratio_d;
   logic             pow2_q,   pow2_d;
   logic             valid_q,  valid_d;
   logic [3:0]       match_q,  match_d;
   logic             tmo_q,    tmo_d;
   logic             first_q,  first_d;

   logic             cnt_pow2;
   logic [4:0]       cnt_log2;

   // The rise strobe is registered, so s_q is the level aligned with it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_q <= '0;
         s_q    <= 1'b0;
         rise_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
         s_q    <= sync_q[SYNC_STAGES-1];
         rise_q <= sync_q[SYNC_STAGES-1] & ~s_q;
      end
   end

   always_comb begin
      cnt_pow2 = ((cnt_q & (cnt_q - CNT_W'(1))) == '0) && (cnt_q >= CNT_W'(2));
      cnt_log2 = 5'd0;
      for (int i = 0; i < CNT_W; i++) begin
         if (cnt_q[i]) cnt_log2 = 5'(i);
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      hi_d     = hi_q;
      period_d = period_q;
      high_d   = high_q;
      ratio_d  = ratio_q;
      pow2_d   = pow2_q;
      valid_d  = 1'b0;
      match_d  = match_q;
      tmo_d    = tmo_q;
      first_d  = first_q;
      if (!enable) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         hi_d    = '0;
         match_d = 4'd0;
         tmo_d   = 1'b0;
         first_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               cnt_d   = '0;
               hi_d    = '0;
               state_d = ST_ARM;
            end
            ST_ARM: begin
               if (rise_q) begin
                  cnt_d   = CNT_W'(1);
                  hi_d    = CNT_W'(1);
                  tmo_d   = 1'b0;
                  first_d = 1'b1;
                  state_d = ST_MEAS;
               end
            end
            ST_MEAS: begin
               // A rise on the same cycle as the timeout limit is still a valid period.
               if (rise_q) begin
                  period_d = cnt_q;
                  high_d   = hi_q;
                  pow2_d   = cnt_pow2;
                  ratio_d  = cnt_pow2 ? cnt_log2 : 5'd0;
                  valid_d  = 1'b1;
                  if (!first_q && (cnt_q == period_q))
                     match_d = (match_q >= LOCK_C) ? LOCK_C : match_q + 4'd1;
                  else
                     match_d = 4'd0;
                  first_d = 1'b0;
                  cnt_d   = CNT_W'(1);
                  hi_d    = CNT_W'(1);
               end else if (cnt_q == TIMEOUT) begin
                  tmo_d   = 1'b1;
                  match_d = 4'd0;
                  cnt_d   = '0;
                  hi_d    = '0;
                  state_d = ST_ARM;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
                  if (s_q) hi_d = hi_q + CNT_W'(1);
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         hi_q     <= '0;
         period_q <= '0;
         high_q   <= '0;
         ratio_q  <= 5'd0;
         pow2_q   <= 1'b0;
         valid_q  <= 1'b0;
         match_q  <= 4'd0;
         tmo_q    <= 1'b0;
         first_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         hi_q     <= hi_d;
         period_q <= period_d;
         high_q   <= high_d;
         ratio_q  <= ratio_d;
         pow2_q   <= pow2_d;
         valid_q  <= valid_d;
         match_q  <= match_d;
         tmo_q    <= tmo_d;
         first_q  <= first_d;
      end
   end

   assign period     = period_q;
   assign high_time  = high_q;
   assign ratio_log2 = ratio_q;
   assign is_pow2    = pow2_q;
   assign valid      = valid_q;
   assign locked     = (match_q == LOCK_C);
   assign timeout    = tmo_q;

endmodule

// File: tb/tb_clk_div_meter.sv
// tb/tb_clk_div_meter.sv - scoreboard bench for clk_div_meter
module tb_clk_div_meter;

   localparam int CNT_W   = 28;
   localparam int TMO     = 2048;
   localparam int LOCK    = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             enable;
   logic             sig_in;
   logic [CNT_W-1:0] period;
   logic [CNT_W-1:0] high_time;
   logic [4:0]       ratio_log2;
   logic             is_pow2;
   logic             valid;
   logic             locked;
   logic             timeout;

   typedef struct {
      int per;
      int hi;
      int lg;
      bit p2;
      bit lk;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   n_tests = 0;
   int   n_fail  = 0;

   clk_div_meter dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .enable    (enable),
      .sig_in    (sig_in),
      .period    (period),
      .high_time (high_time),
      .ratio_log2(ratio_log2),
      .is_pow2   (is_pow2),
      .valid     (valid),
      .locked    (locked),
      .timeout   (timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input longint act, input longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input int per, input int hi, input int lg, input bit p2, input bit lk);
      exp_t e;
      e.per = per; e.hi = hi; e.lg = lg; e.p2 = p2; e.lk = lk;
      sb.push_back(e);
   endtask

   // n periods of h high / l low; rises 2..n each close a period of this shape.
   task automatic wave(input int h, input int l, input int n, input int ep, input int eh,
                       input int el, input bit ex2, input int m_first);
      int m;
      m = m_first;
      for (int i = 0; i < n; i++) begin
         if (i > 0) begin
            push(ep, eh, el, ex2, m == LOCK);
            m = (m >= LOCK) ? LOCK : m + 1;
         end
         sig_in = 1'b1;
         tick(h);
         sig_in = 1'b0;
         tick(l);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, " period"}, period, 0);
      chk({tag, " high_time"}, high_time, 0);
      chk({tag, " ratio_log2"}, ratio_log2, 0);
      chk({tag, " is_pow2"}, is_pow2, 0);
      chk({tag, " valid"}, valid, 0);
      chk({tag, " locked"}, locked, 0);
      chk({tag, " timeout"}, timeout, 0);
   endtask

   always @(negedge clk) begin
      if (valid) begin
         if (sb.size() == 0) begin
            chk("unexpected valid", 1, 0);
         end else begin
            mon_e = sb.pop_front();
            chk("sb period", period, mon_e.per);
            chk("sb high_time", high_time, mon_e.hi);
            chk("sb ratio_log2", ratio_log2, mon_e.lg);
            chk("sb is_pow2", is_pow2, mon_e.p2);
            chk("sb locked", locked, mon_e.lk);
            chk("sb timeout", timeout, 0);
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n  = 1'b0;
      enable = 1'b0;
      sig_in = 1'b0;
      tick(3);
      chk_zero("reset");
      rst_n  = 1'b1;
      enable = 1'b1;
      tick(2);

      // divide-by-4, locks on the 6th rise
      wave(2, 2, 6, 4, 2, 2, 1'b1, 0);
      push(4, 2, 2, 1'b1, 1'b1);
      // divide-by-1024
      wave(512, 512, 3, 1024, 512, 10, 1'b1, 0);
      push(1024, 512, 10, 1'b1, 1'b0);
      chk("div1024 timeout", timeout, 0);
      // period 6 then period 8
      wave(3, 3, 6, 6, 3, 0, 1'b0, 0);
      push(6, 3, 0, 1'b0, 1'b1);
      wave(4, 4, 5, 8, 4, 3, 1'b1, 0);
      push(8, 4, 3, 1'b1, 1'b1);
      sig_in = 1'b1;
      tick(4);
      sig_in = 1'b0;
      tick(TMO - 1);
      chk("pre-timeout timeout", timeout, 0);
      chk("pre-timeout locked", locked, 1);
      tick(1);
      chk("timeout set", timeout, 1);
      chk("timeout locked", locked, 0);
      chk("timeout period held", period, 8);

      // divide-by-2 restart
      wave(1, 1, 4, 2, 1, 1, 1'b1, 0);
      chk("restart timeout cleared", timeout, 0);
      tick(10);

      // reset mid-period
      rst_n = 1'b0;
      tick(1);
      chk_zero("mid reset");
      rst_n = 1'b1;
      wave(2, 2, 7, 4, 2, 2, 1'b1, 0);
      tick(4);
      chk("pre-disable locked", locked, 1);

      enable = 1'b0;
      tick(5);
      chk("disable locked", locked, 0);
      chk("disable timeout", timeout, 0);
      chk("disable period held", period, 4);
      chk("disable high_time held", high_time, 2);
      enable = 1'b1;
      wave(2, 2, 3, 4, 2, 2, 1'b1, 0);
      tick(20);
      chk("scoreboard drained", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
